century_time_counter: RTL and testbench
=======================================

Name: century_time_counter

Overview:
- Timekeeping core of the digital century clock: seconds, minutes, hours, day, month and year-of-century (00-99) counters with a Gregorian month-length/leap-year calendar.
- Sits directly upstream of the divide-by-10 / mod-10 stages. Every field is a 7-bit binary value; those stages split each one into tens and units digits for display.
- Includes a one-second prescaler, a pause control and a single-field set port for the user buttons.

Parameters:
- CLK_PER_SEC, 50000000, clk cycles per second; must be >= 2; the bench uses 4.
- YEAR00_LEAP, 1, 1 = year 00 is a leap year (2000 rule); 0 = not leap.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  1 = time advances; 0 = prescaler and fields hold.
- set_en  input  1  one-cycle write strobe for the set port.
- set_sel  input  3  field select: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year; 6 and 7 are ignored.
- set_value  input  7  binary value to write.
- set_err  output  1  one-cycle pulse, one cycle after a rejected write.
- sec_pulse  output  1  one-cycle pulse on each seconds increment.
- century_wrap  output  1  one-cycle pulse when 99-12-31 23:59:59 rolls to 00-01-01 00:00:00.
- sec, min, hour, day, month, year  output  7 each  current field values.

Behaviour:
- Reset (clk edge with rst=1):
  - sec=0, min=0, hour=0, day=1, month=1, year=0.
  - All pulse outputs 0; prescaler count 0.
  - rst has priority over every other input.
- Prescaler:
  - Counts 0..CLK_PER_SEC-1 while run=1.
  - The terminal count produces an internal tick and wraps to 0.
  - run=0 freezes the count; it does not clear it.
- Tick rules:
  - On a tick, sec increments and sec_pulse=1 in the same cycle the fields update, i.e. registered alongside them.
  - Fields update one cycle after the terminal count is reached.
- Ripple chain (all fields update in the same clock edge):
  - sec 59->0 carries into min.
  - min 59->0 carries into hour.
  - hour 23->0 carries into day.
  - day at month length ->1 carries into month.
  - month 12->1 carries into year.
  - year 99->0 asserts century_wrap.
- Month lengths:
  - 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
  - February: 29 if leap, else 28.
  - Leap test: year[1:0]==0. Year 0 is leap only if YEAR00_LEAP=1.
- Set port: valid ranges are sec/min 0-59, hour 0-23, day 1..length(month, year), month 1-12, year 0-99.
  - Valid write: the field takes set_value on that edge.
  - Out-of-range write: no field changes; set_err pulses the next cycle.
  - set_sel 6 or 7: ignored, no error.
- Day clamping:
  - A month or year write that makes the current day exceed the new month length also sets day = new length in the same edge.
  - Example: day 31, write month=4 -> day 30.
  - Example: 02-29 in leap year 04, write year=05 -> day 28.
- Set/tick collision:
  - If set_en=1 on the edge where a tick would apply, the write applies and the whole increment is dropped; sec_pulse stays 0.
  - The prescaler still wraps normally.
  - Writing sec also clears the prescaler to 0, so the new second starts a full second.
- Writes are accepted whether run is 0 or 1.
- Outputs are registered and change only on clk edges. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package clock_pkg holds:
  - Field-select constants SEL_SEC..SEL_YEAR (3-bit).
  - Limits MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23, MAX_MONTH=12, MAX_YEAR=99.
  - A 7-bit month-length function taking (month, leap).
- One sub-module, one_sec_prescaler:
  - Parameter CLK_PER_SEC.
  - Inputs clk, rst, run, clear; output tick.
- The calendar ripple and set logic stay in this module.

Test Plan (CLK_PER_SEC=4):
- Reset, run=1 for 8 clk -> sec_pulse at the 4th and 8th cycle after reset release; sec=2; other fields at reset values.
- Set fields to year 99, month 12, day 31, hour 23, min 59, sec 59, then one tick -> century_wrap=1 for one cycle; fields 0/1/1/0/0/0.
- Feb rollover:
  - Year 3: 02-28 23:59:59 + tick -> 03-01.
  - Year 4: same start -> 02-29.
  - Year 0: same start -> 02-29 with YEAR00_LEAP=1, 03-01 with YEAR00_LEAP=0.
- Set errors:
  - Write min=60 -> set_err=1 next cycle, min unchanged.
  - Write day=31 with month=4 -> set_err=1.
  - Write set_sel=7 -> no set_err.
- Clamp: with day=31, month=1, write month=2 in year 1 -> month=2, day=28, set_err=0.
- Collision:
  - set_en (hour=5) asserted on the tick edge -> hour=5, sec unchanged, sec_pulse=0.
  - run=0 for 10 cycles -> no pulses; after run=1, the next tick arrives after the remaining prescaler count.
  - rst asserted mid-count -> all fields back to reset values on that edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared field-select codes, field limits and calendar helpers for the century clock.
package clock_pkg;
    localparam logic [2:0] SEL_SEC   = 3'd0;
    localparam logic [2:0] SEL_MIN   = 3'd1;
    localparam logic [2:0] SEL_HOUR  = 3'd2;
    localparam logic [2:0] SEL_DAY   = 3'd3;
    localparam logic [2:0] SEL_MONTH = 3'd4;
    localparam logic [2:0] SEL_YEAR  = 3'd5;

    localparam logic [6:0] MAX_SEC   = 7'd59;
    localparam logic [6:0] MAX_MIN   = 7'd59;
    localparam logic [6:0] MAX_HOUR  = 7'd23;
    localparam logic [6:0] MAX_MONTH = 7'd12;
    localparam logic [6:0] MAX_YEAR  = 7'd99;

    function automatic logic [6:0] month_len(input logic [6:0] month, input logic leap);
        case (month)
            7'd4, 7'd6, 7'd9, 7'd11: return 7'd30;
            7'd2:                    return leap ? 7'd29 : 7'd28;
            default:                 return 7'd31;
        endcase
    endfunction

    // Year 00 is the only multiple of four whose leap status is configurable.
    function automatic logic is_leap(input logic [6:0] year, input logic leap00);
        return (year[1:0] == 2'b00) && ((year != 7'd0) || leap00);
    endfunction
endpackage

// File: rtl/one_sec_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_PER_SEC cycles while run is high.
module one_sec_prescaler #(
    parameter int CLK_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_PER_SEC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (run)
            cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
endmodule

// File: rtl/century_time_counter.sv
// Seconds-to-year-of-century counter with Gregorian month lengths and a single-field set port.
module century_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_PER_SEC = 50000000,
    parameter bit YEAR00_LEAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_en,
    input  logic [2:0] set_sel,
    input  logic [6:0] set_value,
    output logic       set_err,
    output logic       sec_pulse,
    output logic       century_wrap,
    output logic [6:0] sec,
    output logic [6:0] min,
    output logic [6:0] hour,
    output logic [6:0] day,
    output logic [6:0] month,
    output logic [6:0] year
);
    logic       tick;
    logic       presc_clear;
    logic       leap_cur;
    logic [6:0] len_cur;
    logic [6:0] len_new_month;
    logic [6:0] len_new_year;
    logic       set_ok;

    // A second starts afresh whenever the seconds field is written.
    assign presc_clear = set_en && (set_sel == SEL_SEC) && (set_value <= MAX_SEC);

    one_sec_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (presc_clear),
        .tick  (tick)
    );

    always_comb begin
        leap_cur      = is_leap(year, YEAR00_LEAP);
        len_cur       = month_len(month, leap_cur);
        len_new_month = month_len(set_value, leap_cur);
        len_new_year  = month_len(month, is_leap(set_value, YEAR00_LEAP));
        set_ok        = 1'b0;
        case (set_sel)
            SEL_SEC:   set_ok = (set_value <= MAX_SEC);
            SEL_MIN:   set_ok = (set_value <= MAX_MIN);
            SEL_HOUR:  set_ok = (set_value <= MAX_HOUR);
            SEL_DAY:   set_ok = (set_value != 7'd0) && (set_value <= len_cur);
            SEL_MONTH: set_ok = (set_value != 7'd0) && (set_value <= MAX_MONTH);
            SEL_YEAR:  set_ok = (set_value <= MAX_YEAR);
            default:   set_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec          <= 7'd0;
            min          <= 7'd0;
            hour         <= 7'd0;
            day          <= 7'd1;
            month        <= 7'd1;
            year         <= 7'd0;
            sec_pulse    <= 1'b0;
            century_wrap <= 1'b0;
            set_err      <= 1'b0;
        end else begin
            sec_pulse    <= 1'b0;
            century_wrap <= 1'b0;
            set_err      <= 1'b0;
            // A write always wins over a coincident tick; that second is simply lost.
            if (set_en) begin
                if (set_ok) begin
                    case (set_sel)
                        SEL_SEC:  sec  <= set_value;
                        SEL_MIN:  min  <= set_value;
                        SEL_HOUR: hour <= set_value;
                        SEL_DAY:  day  <= set_value;
                        SEL_MONTH: begin
                            month <= set_value;
                            if (day > len_new_month) day <= len_new_month;
                        end
                        SEL_YEAR: begin
                            year <= set_value;
                            if (day > len_new_year) day <= len_new_year;
                        end
                        default: ;
                    endcase
                end else if (set_sel <= SEL_YEAR) begin
                    set_err <= 1'b1;
                end
            end else if (tick) begin
                sec_pulse <= 1'b1;
                if (sec < MAX_SEC) begin
                    sec <= sec + 7'd1;
                end else begin
                    sec <= 7'd0;
                    if (min < MAX_MIN) begin
                        min <= min + 7'd1;
                    end else begin
                        min <= 7'd0;
                        if (hour < MAX_HOUR) begin
                            hour <= hour + 7'd1;
                        end else begin
                            hour <= 7'd0;
                            if (day < len_cur) begin
                                day <= day + 7'd1;
                            end else begin
                                day <= 7'd1;
                                if (month < MAX_MONTH) begin
                                    month <= month + 7'd1;
                                end else begin
                                    month <= 7'd1;
                                    if (year < MAX_YEAR) begin
                                        year <= year + 7'd1;
                                    end else begin
                                        year         <= 7'd0;
                                        century_wrap <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_century_time_counter.sv
// Directed bench for century_time_counter with CLK_PER_SEC=4; a second instance covers YEAR00_LEAP=0.
module tb_century_time_counter;
    import clock_pkg::*;

    logic       clk = 1'b0;
    logic       rst, run, set_en;
    logic [2:0] set_sel;
    logic [6:0] set_value;

    logic       set_err, sec_pulse, century_wrap;
    logic [6:0] sec, min, hour, day, month, year;
    logic       set_err0, sec_pulse0, century_wrap0;
    logic [6:0] sec0, min0, hour0, day0, month0, year0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    century_time_counter #(.CLK_PER_SEC(4), .YEAR00_LEAP(1'b1)) dut (
        .clk(clk), .rst(rst), .run(run), .set_en(set_en), .set_sel(set_sel),
        .set_value(set_value), .set_err(set_err), .sec_pulse(sec_pulse),
        .century_wrap(century_wrap), .sec(sec), .min(min), .hour(hour),
        .day(day), .month(month), .year(year)
    );

    century_time_counter #(.CLK_PER_SEC(4), .YEAR00_LEAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .run(run), .set_en(set_en), .set_sel(set_sel),
        .set_value(set_value), .set_err(set_err0), .sec_pulse(sec_pulse0),
        .century_wrap(century_wrap0), .sec(sec0), .min(min0), .hour(hour0),
        .day(day0), .month(month0), .year(year0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_field(input logic [2:0] sel, input logic [6:0] val);
        set_en    = 1'b1;
        set_sel   = sel;
        set_value = val;
        step(1);
        set_en    = 1'b0;
    endtask

    task automatic load(input logic [6:0] y, mo, d, h, mi, s);
        set_field(SEL_YEAR, y);
        set_field(SEL_MONTH, mo);
        set_field(SEL_DAY, d);
        set_field(SEL_HOUR, h);
        set_field(SEL_MIN, mi);
        set_field(SEL_SEC, s);
    endtask

    // Assumes the prescaler sits at 0 (e.g. right after a seconds write).
    task automatic one_tick();
        run = 1'b1;
        step(4);
        run = 1'b0;
    endtask

    task automatic chk_date(input string tag, input logic [6:0] y, mo, d, h, mi, s);
        chk({tag, ".year"}, year, y);
        chk({tag, ".month"}, month, mo);
        chk({tag, ".day"}, day, d);
        chk({tag, ".hour"}, hour, h);
        chk({tag, ".min"}, min, mi);
        chk({tag, ".sec"}, sec, s);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; set_en = 1'b0; set_sel = 3'd0; set_value = 7'd0;
        step(2);
        chk_date("reset", 0, 1, 1, 0, 0, 0);
        chk("reset.sec_pulse", sec_pulse, 0);
        chk("reset.set_err", set_err, 0);
        chk("reset.century_wrap", century_wrap, 0);

        // Free run: pulses on the 4th and 8th cycle after release.
        rst = 1'b0; run = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk($sformatf("run.pulse%0d", i), sec_pulse, (i == 4 || i == 8));
        end
        chk_date("run8", 0, 1, 1, 0, 0, 2);
        run = 1'b0;

        // Century rollover.
        load(99, 12, 31, 23, 59, 59);
        run = 1'b1;
        step(3);
        chk("wrap.pre_sec", sec, 59);
        chk("wrap.pre_cw", century_wrap, 0);
        step(1);
        run = 1'b0;
        chk("wrap.cw", century_wrap, 1);
        chk("wrap.pulse", sec_pulse, 1);
        chk_date("wrap", 0, 1, 1, 0, 0, 0);
        step(1);
        chk("wrap.cw_clear", century_wrap, 0);

        // February rollover in non-leap and leap years.
        load(3, 2, 28, 23, 59, 59);
        one_tick();
        chk_date("feb_y3", 3, 3, 1, 0, 0, 0);
        load(4, 2, 28, 23, 59, 59);
        one_tick();
        chk_date("feb_y4", 4, 2, 29, 0, 0, 0);

        // Year write shortens February: 04-02-29 -> 05-02-28.
        set_field(SEL_YEAR, 5);
        chk("clamp_year.day", day, 28);
        chk("clamp_year.year", year, 5);
        chk("clamp_year.err", set_err, 0);

        load(0, 2, 28, 23, 59, 59);
        one_tick();
        chk_date("feb_y0_leap", 0, 2, 29, 0, 0, 0);
        chk("feb_y0_noleap.month", month0, 3);
        chk("feb_y0_noleap.day", day0, 1);

        // Rejected and ignored writes.
        set_field(SEL_MIN, 60);
        chk("err_min.err", set_err, 1);
        chk("err_min.min", min, 0);
        step(1);
        chk("err_min.err_pulse", set_err, 0);
        set_field(SEL_MONTH, 4);
        chk("apr.day", day, 29);
        set_field(SEL_DAY, 31);
        chk("err_day.err", set_err, 1);
        chk("err_day.day", day, 29);
        set_field(SEL_DAY, 30);
        chk("ok_day30.day", day, 30);
        chk("ok_day30.err", set_err, 0);
        set_field(3'd7, 7'd5);
        chk("sel7.err", set_err, 0);
        chk_date("sel7", 0, 4, 30, 0, 0, 0);
        set_field(SEL_MONTH, 0);
        chk("err_month0.err", set_err, 1);

        // Month write clamps the day: 01-31 in year 1 -> 02-28.
        set_field(SEL_YEAR, 1);
        set_field(SEL_MONTH, 1);
        set_field(SEL_DAY, 31);
        set_field(SEL_MONTH, 2);
        chk("clamp_month.month", month, 2);
        chk("clamp_month.day", day, 28);
        chk("clamp_month.err", set_err, 0);

        // Write colliding with a tick drops the increment; prescaler still wraps.
        run = 1'b1;
        step(3);
        set_field(SEL_HOUR, 5);
        chk("coll.hour", hour, 5);
        chk("coll.sec", sec, 0);
        chk("coll.pulse", sec_pulse, 0);
        step(3);
        chk("coll.after3", sec_pulse, 0);
        step(1);
        chk("coll.next_pulse", sec_pulse, 1);
        chk("coll.next_sec", sec, 1);

        // Pause mid-count, then resume for the remaining two cycles.
        step(2);
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk($sformatf("pause.pulse%0d", i), sec_pulse, 0);
        end
        chk("pause.sec", sec, 1);
        run = 1'b1;
        step(1);
        chk("resume.first", sec_pulse, 0);
        step(1);
        chk("resume.pulse", sec_pulse, 1);
        chk("resume.sec", sec, 2);

        // Reset mid-count restores everything and restarts the prescaler.
        step(2);
        rst = 1'b1;
        step(1);
        chk_date("rst_mid", 0, 1, 1, 0, 0, 0);
        chk("rst_mid.pulse", sec_pulse, 0);
        rst = 1'b0;
        step(3);
        chk("rst_mid.pre", sec_pulse, 0);
        step(1);
        chk("rst_mid.pulse4", sec_pulse, 1);
        chk("rst_mid.sec", sec, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
